l1_dma_ctrl: RTL and testbench

//  Line-refill/writeback sequencer for the L1 inst/data memories. Owns their DMA ports.

---
 rtl/l1_dma_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_l1_dma_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dma_ctrl.sv
// L1 line-refill / writeback DMA sequencer: one burst at a time on the external channel.
// Optional `L1_DMA_RR_ARB_EN: round-robin between data and inst refills (default fixed priority).
module l1_dma_ctrl #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned READ_BURST_LEN  = 8,
    parameter int unsigned WRITE_BURST_LEN = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  inst_refill_req,
    input  logic [ADDR_WIDTH-1:0] inst_refill_addr,
    output logic                  inst_refill_done,
    input  logic                  data_refill_req,
    input  logic [ADDR_WIDTH-1:0] data_refill_addr,
    output logic                  data_refill_done,
    input  logic                  data_wb_req,
    input  logic [ADDR_WIDTH-1:0] data_wb_addr,
    output logic                  data_wb_done,
    output logic                  ext_rd_req,
    output logic [ADDR_WIDTH-1:0] ext_rd_addr,
    input  logic                  ext_rd_ack,
    input  logic                  ext_rd_valid,
    input  logic [DATA_WIDTH-1:0] ext_rd_data,
    output logic                  ext_wr_req,
    output logic [ADDR_WIDTH-1:0] ext_wr_addr,
    input  logic                  ext_wr_ack,
    output logic                  ext_wr_valid,
    output logic [DATA_WIDTH-1:0] ext_wr_data,
    output logic                  ext_wr_last,
    input  logic                  ext_wr_ready,
    output logic [ADDR_WIDTH-1:0] dma_inst_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_inst_mem_wdata,
    output logic                  inst_mem_write,
    output logic [ADDR_WIDTH-1:0] dma_data_mem_waddr,
    output logic [DATA_WIDTH-1:0] dma_data_mem_wdata,
    output logic                  data_mem_write,
    output logic                  data_mem_write_ctrl_by,
    output logic [ADDR_WIDTH-1:0] dma_data_mem_raddr,
    output logic                  data_mem_read_ctrl_by,
    input  logic [DATA_WIDTH-1:0] data_mem_rdata,
    output logic                  busy
);

    localparam int unsigned MaxLen = (READ_BURST_LEN > WRITE_BURST_LEN) ?
                                     READ_BURST_LEN : WRITE_BURST_LEN;
    localparam int unsigned CntW   = $clog2(MaxLen);
    localparam logic [CntW-1:0]       RdLast = CntW'(READ_BURST_LEN - 1);
    localparam logic [CntW-1:0]       WrLast = CntW'(WRITE_BURST_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] RdMask = ADDR_WIDTH'(READ_BURST_LEN * 4 - 1);
    localparam logic [ADDR_WIDTH-1:0] WrMask = ADDR_WIDTH'(WRITE_BURST_LEN * 4 - 1);

    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrAddr, StWrData, StDone} state_e;
    typedef enum logic [1:0] {SrcInst, SrcData, SrcWb} src_e;

    state_e                state_q;
    src_e                  src_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CntW-1:0]       cnt_q;
    logic                  rd_req_q, wr_req_q;
    logic [ADDR_WIDTH-1:0] mem_waddr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  inst_wr_q, data_wr_q, data_ctrl_q;
    logic                  grant_dref, grant_iref;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic                  wr_phase;

    assign beat_addr = base_q + ADDR_WIDTH'({cnt_q, 2'b00});

`ifdef L1_DMA_RR_ARB_EN
    // Set when data was the last refill served; reset value lets inst win the first tie.
    logic last_data_q;

    always_comb begin
        grant_dref = !data_wb_req && data_refill_req && (!inst_refill_req || !last_data_q);
        grant_iref = !data_wb_req && inst_refill_req && !grant_dref;
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            last_data_q <= 1'b1;
        end else if (state_q == StIdle && (grant_dref || grant_iref)) begin
            last_data_q <= grant_dref;
        end
    end
`else
    always_comb begin
        grant_dref = !data_wb_req && data_refill_req;
        grant_iref = !data_wb_req && !data_refill_req && inst_refill_req;
    end
`endif

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q     <= StIdle;
            src_q       <= SrcInst;
            base_q      <= '0;
            cnt_q       <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            inst_wr_q   <= 1'b0;
            data_wr_q   <= 1'b0;
            data_ctrl_q <= 1'b0;
        end else begin
            inst_wr_q <= 1'b0;
            data_wr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (data_wb_req) begin
                        src_q    <= SrcWb;
                        base_q   <= data_wb_addr & ~WrMask;
                        wr_req_q <= 1'b1;
                        state_q  <= StWrAddr;
                    end else if (grant_dref) begin
                        src_q       <= SrcData;
                        base_q      <= data_refill_addr & ~RdMask;
                        rd_req_q    <= 1'b1;
                        data_ctrl_q <= 1'b1;
                        state_q     <= StRdAddr;
                    end else if (grant_iref) begin
                        src_q    <= SrcInst;
                        base_q   <= inst_refill_addr & ~RdMask;
                        rd_req_q <= 1'b1;
                        state_q  <= StRdAddr;
                    end
                end
                StRdAddr: begin
                    if (ext_rd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= StRdData;
                    end
                end
                StRdData: begin
                    // Beat is captured here and written to the memory on the following cycle.
                    if (ext_rd_valid) begin
                        mem_waddr_q <= beat_addr;
                        mem_wdata_q <= ext_rd_data;
                        inst_wr_q   <= (src_q == SrcInst);
                        data_wr_q   <= (src_q == SrcData);
                        if (cnt_q == RdLast) begin
                            cnt_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StWrAddr: begin
                    if (ext_wr_ack) begin
                        wr_req_q <= 1'b0;
                        state_q  <= StWrData;
                    end
                end
                StWrData: begin
                    if (ext_wr_ready) begin
                        if (cnt_q == WrLast) begin
                            cnt_q   <= '0;
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    data_ctrl_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_phase = (state_q == StWrData);

    assign busy             = (state_q != StIdle);
    assign inst_refill_done = (state_q == StDone) && (src_q == SrcInst);
    assign data_refill_done = (state_q == StDone) && (src_q == SrcData);
    assign data_wb_done     = (state_q == StDone) && (src_q == SrcWb);

    assign ext_rd_req  = rd_req_q;
    assign ext_rd_addr = base_q;
    assign ext_wr_req  = wr_req_q;
    assign ext_wr_addr = base_q;

    assign ext_wr_valid          = wr_phase;
    assign ext_wr_data           = wr_phase ? data_mem_rdata : '0;
    assign ext_wr_last           = wr_phase && (cnt_q == WrLast);
    assign dma_data_mem_raddr    = wr_phase ? beat_addr : '0;
    assign data_mem_read_ctrl_by = wr_phase;

    assign dma_inst_mem_waddr     = mem_waddr_q;
    assign dma_inst_mem_wdata     = mem_wdata_q;
    assign inst_mem_write         = inst_wr_q;
    assign dma_data_mem_waddr     = mem_waddr_q;
    assign dma_data_mem_wdata     = mem_wdata_q;
    assign data_mem_write         = data_wr_q;
    assign data_mem_write_ctrl_by = data_ctrl_q;

endmodule

// File: tb/tb_l1_dma_ctrl.sv
// Scoreboard bench for l1_dma_ctrl: expected memory writes and external write beats are
// queued when stimulus is driven and checked when the DUT produces them.
module tb_l1_dma_ctrl;

    localparam int LEN = 8;

    logic        clk = 1'b0;
    logic        cpu_rst_n;
    logic        inst_refill_req, data_refill_req, data_wb_req;
    logic [31:0] inst_refill_addr, data_refill_addr, data_wb_addr;
    logic        inst_refill_done, data_refill_done, data_wb_done;
    logic        ext_rd_req, ext_rd_ack, ext_rd_valid;
    logic [31:0] ext_rd_addr, ext_rd_data;
    logic        ext_wr_req, ext_wr_ack, ext_wr_valid, ext_wr_last, ext_wr_ready;
    logic [31:0] ext_wr_addr, ext_wr_data;
    logic [31:0] dma_inst_mem_waddr, dma_inst_mem_wdata;
    logic [31:0] dma_data_mem_waddr, dma_data_mem_wdata, dma_data_mem_raddr, data_mem_rdata;
    logic        inst_mem_write, data_mem_write, data_mem_write_ctrl_by, data_mem_read_ctrl_by;
    logic        busy;

    always #5 clk = ~clk;

    // Data memory model: each word's content is derived from its own address.
    assign data_mem_rdata = {16'hD0D0, dma_data_mem_raddr[15:0]};

    l1_dma_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .READ_BURST_LEN (LEN),
        .WRITE_BURST_LEN(LEN)
    ) dut (
        .cpu_clk               (clk),
        .cpu_rst_n             (cpu_rst_n),
        .inst_refill_req       (inst_refill_req),
        .inst_refill_addr      (inst_refill_addr),
        .inst_refill_done      (inst_refill_done),
        .data_refill_req       (data_refill_req),
        .data_refill_addr      (data_refill_addr),
        .data_refill_done      (data_refill_done),
        .data_wb_req           (data_wb_req),
        .data_wb_addr          (data_wb_addr),
        .data_wb_done          (data_wb_done),
        .ext_rd_req            (ext_rd_req),
        .ext_rd_addr           (ext_rd_addr),
        .ext_rd_ack            (ext_rd_ack),
        .ext_rd_valid          (ext_rd_valid),
        .ext_rd_data           (ext_rd_data),
        .ext_wr_req            (ext_wr_req),
        .ext_wr_addr           (ext_wr_addr),
        .ext_wr_ack            (ext_wr_ack),
        .ext_wr_valid          (ext_wr_valid),
        .ext_wr_data           (ext_wr_data),
        .ext_wr_last           (ext_wr_last),
        .ext_wr_ready          (ext_wr_ready),
        .dma_inst_mem_waddr    (dma_inst_mem_waddr),
        .dma_inst_mem_wdata    (dma_inst_mem_wdata),
        .inst_mem_write        (inst_mem_write),
        .dma_data_mem_waddr    (dma_data_mem_waddr),
        .dma_data_mem_wdata    (dma_data_mem_wdata),
        .data_mem_write        (data_mem_write),
        .data_mem_write_ctrl_by(data_mem_write_ctrl_by),
        .dma_data_mem_raddr    (dma_data_mem_raddr),
        .data_mem_read_ctrl_by (data_mem_read_ctrl_by),
        .data_mem_rdata        (data_mem_rdata),
        .busy                  (busy)
    );

    typedef struct packed {
        logic        is_data;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } ext_wr_t;

    mem_wr_t mem_q[$];
    ext_wr_t wr_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_mem_wr = 0;
    int n_done = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;
    always @(negedge clk) begin
        mem_wr_t me;
        ext_wr_t we;
        if (inst_mem_write || data_mem_write) begin
            n_mem_wr++;
            check_val("write_expected", 32'(mem_q.size() != 0), 1);
            if (mem_q.size() != 0) begin
                me = mem_q.pop_front();
                check_val("wr_port_data", 32'(data_mem_write), 32'(me.is_data));
                check_val("wr_port_inst", 32'(inst_mem_write), 32'(!me.is_data));
                check_val("wr_addr", me.is_data ? dma_data_mem_waddr : dma_inst_mem_waddr,
                          me.addr);
                check_val("wr_data", me.is_data ? dma_data_mem_wdata : dma_inst_mem_wdata,
                          me.data);
                if (me.is_data) check_val("wr_ctrl_by", 32'(data_mem_write_ctrl_by), 1);
            end
        end
        if (ext_wr_valid && ext_wr_ready) begin
            check_val("beat_expected", 32'(wr_q.size() != 0), 1);
            if (wr_q.size() != 0) begin
                we = wr_q.pop_front();
                check_val("ext_wr_data", ext_wr_data, we.data);
                check_val("ext_wr_last", 32'(ext_wr_last), 32'(we.last));
                check_val("rd_ctrl_by", 32'(data_mem_read_ctrl_by), 1);
            end
        end
        if (stall_prev) begin
            check_val("stall_valid", 32'(ext_wr_valid), 1);
            check_val("stall_data", ext_wr_data, stall_data);
        end
        stall_prev = ext_wr_valid && !ext_wr_ready;
        stall_data = ext_wr_data;
        if (inst_refill_done || data_refill_done || data_wb_done) n_done++;
        if (inst_refill_done) check_val("inst_done_with_write", 32'(inst_mem_write), 1);
        if (data_refill_done) check_val("data_done_with_write", 32'(data_mem_write), 1);
    end

    function automatic logic any_output();
        return |{inst_refill_done, data_refill_done, data_wb_done, ext_rd_req, ext_rd_addr,
                 ext_wr_req, ext_wr_addr, ext_wr_valid, ext_wr_data, ext_wr_last,
                 dma_inst_mem_waddr, dma_inst_mem_wdata, inst_mem_write,
                 dma_data_mem_waddr, dma_data_mem_wdata, data_mem_write,
                 data_mem_write_ctrl_by, dma_data_mem_raddr, data_mem_read_ctrl_by, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serves one read burst already requested; abort_beat < LEN asserts reset at that beat.
    task automatic serve_read(input bit is_data, input logic [31:0] base, input logic [31:0] d0,
                              input int ack_dly, input int abort_beat);
        int t = 0;
        int done_before;
        while (!ext_rd_req && t < 20) begin
            tick();
            t++;
        end
        check_val("rd_req_seen", 32'(ext_rd_req), 1);
        if (!ext_rd_req) return;
        check_val("rd_addr", ext_rd_addr, base);
        check_val("busy_rd", 32'(busy), 1);
        repeat (ack_dly) begin
            tick();
            check_val("rd_req_held", 32'(ext_rd_req), 1);
            check_val("rd_addr_held", ext_rd_addr, base);
        end
        ext_rd_ack = 1'b1;
        tick();
        ext_rd_ack = 1'b0;
        check_val("rd_req_after_ack", 32'(ext_rd_req), 0);
        done_before = n_done;
        for (int k = 0; k < LEN; k++) begin
            ext_rd_valid = 1'b1;
            ext_rd_data  = d0 + 32'(k);
            if (k == abort_beat) begin
                cpu_rst_n = 1'b0;
                if (is_data) data_refill_req = 1'b0;
                else inst_refill_req = 1'b0;
            end else begin
                mem_q.push_back('{is_data, base + 32'(4 * k), d0 + 32'(k)});
            end
            tick();
            if (k == abort_beat) break;
        end
        ext_rd_valid = 1'b0;
        if (abort_beat < LEN) begin
            check_val("rst_outputs_zero", 32'(any_output()), 0);
            cpu_rst_n = 1'b1;
            repeat (4) tick();
            check_val("rst_no_done", 32'(n_done), 32'(done_before));
            check_val("rst_idle", 32'(busy), 0);
            check_val("rst_queue_drained", 32'(mem_q.size()), 0);
            return;
        end
        check_val("rd_done", 32'(is_data ? data_refill_done : inst_refill_done), 1);
        tick();
        check_val("rd_done_1cyc", 32'(inst_refill_done | data_refill_done), 0);
        check_val("rd_busy_after", 32'(busy), 0);
        if (is_data) data_refill_req = 1'b0;
        else inst_refill_req = 1'b0;
    endtask

    task automatic serve_write(input logic [31:0] base);
        int t = 0;
        logic [31:0] a;
        bit rdy[10] = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
        while (!ext_wr_req && t < 20) begin
            tick();
            t++;
        end
        check_val("wr_req_seen", 32'(ext_wr_req), 1);
        if (!ext_wr_req) return;
        check_val("ext_wr_addr", ext_wr_addr, base);
        tick();
        check_val("wr_req_held", 32'(ext_wr_req), 1);
        ext_wr_ack = 1'b1;
        tick();
        ext_wr_ack = 1'b0;
        check_val("wr_req_after_ack", 32'(ext_wr_req), 0);
        for (int k = 0; k < LEN; k++) begin
            a = base + 32'(4 * k);
            wr_q.push_back('{{16'hD0D0, a[15:0]}, k == LEN - 1});
        end
        for (int i = 0; i < 10; i++) begin
            ext_wr_ready = rdy[i];
            tick();
        end
        ext_wr_ready = 1'b0;
        check_val("wb_done", 32'(data_wb_done), 1);
        check_val("wb_valid_off", 32'(ext_wr_valid), 0);
        tick();
        check_val("wb_done_1cyc", 32'(data_wb_done), 0);
        data_wb_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        cpu_rst_n = 1'b0;
        inst_refill_req = 1'b0; data_refill_req = 1'b0; data_wb_req = 1'b0;
        inst_refill_addr = '0; data_refill_addr = '0; data_wb_addr = '0;
        ext_rd_ack = 1'b0; ext_rd_valid = 1'b0; ext_rd_data = '0;
        ext_wr_ack = 1'b0; ext_wr_ready = 1'b0;
        repeat (3) tick();
        check_val("reset_outputs", 32'(any_output()), 0);
        cpu_rst_n = 1'b1;
        tick();

        // Inst refill with unaligned address
        inst_refill_addr = 32'h0000_0047;
        inst_refill_req  = 1'b1;
        serve_read(1'b0, 32'h0000_0040, 32'hA0, 2, LEN);

        // Writeback with ready stalls
        data_wb_addr = 32'h0000_0080;
        data_wb_req  = 1'b1;
        serve_write(32'h0000_0080);

        // Simultaneous refills: data first, then inst
        data_refill_addr = 32'h1234_5678;
        inst_refill_addr = 32'h0000_0200;
        data_refill_req  = 1'b1;
        inst_refill_req  = 1'b1;
        serve_read(1'b1, 32'h1234_5660, 32'h100, 1, LEN);
        serve_read(1'b0, 32'h0000_0200, 32'h200, 0, LEN);

        // Reset mid-burst at beat 4
        data_refill_addr = 32'h0000_0300;
        data_refill_req  = 1'b1;
        serve_read(1'b1, 32'h0000_0300, 32'h300, 1, 4);

        // Spurious read beats while idle
        w0 = n_mem_wr;
        ext_rd_valid = 1'b1;
        ext_rd_data  = 32'hDEAD_BEEF;
        repeat (3) tick();
        ext_rd_valid = 1'b0;
        repeat (2) tick();
        check_val("idle_no_write", 32'(n_mem_wr), 32'(w0));
        check_val("idle_not_busy", 32'(busy), 0);

        // Top-of-address-space line
        inst_refill_addr = 32'hFFFF_FFF0;
        inst_refill_req  = 1'b1;
        serve_read(1'b0, 32'hFFFF_FFE0, 32'h50, 0, LEN);

        // Inst request pulsed while busy is never served
        data_refill_addr = 32'h0000_0400;
        data_refill_req  = 1'b1;
        fork
            serve_read(1'b1, 32'h0000_0400, 32'h600, 3, LEN);
            begin
                repeat (2) tick();
                inst_refill_addr = 32'h0000_0800;
                inst_refill_req  = 1'b1;
                tick();
                inst_refill_req  = 1'b0;
            end
        join
        repeat (5) tick();
        check_val("dropped_no_rd_req", 32'(ext_rd_req), 0);
        check_val("dropped_not_busy", 32'(busy), 0);

        check_val("mem_queue_empty", 32'(mem_q.size()), 0);
        check_val("wr_queue_empty", 32'(wr_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
